cw_input: RTL and testbench
===========================

// Module: cw_input
// PURPOSE
//  Clockwise-link input port of the ring router; receiving end of the cwso/cwro/cwdo link driven by the upstream CW output port.
//  Captures link flits into one even and one odd virtual-channel buffer, selected by polarity at capture.
//  Routes each buffered flit by its hop field: hop==0 goes to the local PE output port, hop!=0 to the downstream CW output port.
//  Holds each flit under a request/grant handshake; drives cwri to tell the sender a VC slot is free.
// PARAMETERS
//  DATA_WIDTH  64  flit width; hop field is bits [55:48] (fixed, needs DATA_WIDTH>=56)
// PORTS
//  clk               in   1    clock
//  rst               in   1    reset, synchronous, active-high
//  polarity          in   1    global VC phase, toggles every clk
//  cwsi              in   1    link send strobe from upstream
//  cwdi              in   64   link data from upstream
//  cwri              out  1    link ready to upstream
//  data_out_even     out  64   even VC flit to output ports
//  data_out_odd      out  64   odd VC flit to output ports
//  request_cw_even   out  1    even flit wants CW output (hop!=0)
//  request_cw_odd    out  1    odd flit wants CW output
//  request_pe_even   out  1    even flit wants PE output (hop==0)
//  request_pe_odd    out  1    odd flit wants PE output
//  grant_cw_even     in   1    grants from the CW output port
//  grant_cw_odd      in   1
//  grant_pe_even     in   1    grants from the PE output port
//  grant_pe_odd      in   1
//  overflow_err      out  1    sticky: flit arrived while target VC busy
// BEHAVIOUR
//  - All state is updated on posedge clk. Reset forces both VCs to EMPTY, data_out_* to 0, requests to 0 and overflow_err to 0.
//  - Reset applied mid-handshake drops any held flit immediately; the next cycle shows requests low.
//  - Capture: at posedge with cwsi=1, the flit goes to the even VC if the pre-edge polarity is 1, else to the odd VC.
//    The sender launches on the negedge after its own polarity check, which produces this mapping.
//  - cwri = polarity ? (odd_state==EMPTY) : (even_state==EMPTY). It is combinational from registered state and polarity.
//  - Per-VC FSM:
//      EMPTY   -> FULL     on capture to this VC
//      FULL    -> GRANTED  when grant_x is high, where x is the destination selected at capture
//      GRANTED -> EMPTY    when grant_x is low
//  - FULL: data_out_* holds the flit, and exactly one request_* is high, chosen by hop (hop==0 gives pe, else cw).
//  - GRANTED: requests are low and data_out_* is still held stable.
//    Reason: the output port keeps re-sampling data while its grant is high, so the flit must not change until grant falls.
//  - Latency: the request rises the cycle after capture. The slot frees the cycle after grant falls.
//    cwri can be high again in the first cycle of matching polarity after that.
//  - The destination is latched at capture. A grant on the non-selected destination is ignored.
//  - Even and odd VCs are fully independent. Simultaneous events on both VCs are all legal.
//  - Capture into a non-EMPTY VC (sender ignored cwri): the flit is dropped, the VC keeps its flit, and overflow_err is set until rst.
//  - No hop arithmetic here; the CW output port decrements hop on send.
// STRUCTURE
//  - Shared router package/header: VC state encodings (EMPTY/FULL/GRANTED one-hot), HOP_MSB=55, HOP_LSB=48, DATA_WIDTH default.
//  - Sub-module cw_input_vc: one VC buffer plus its FSM, request decode and grant tracking; instantiated twice (even, odd).
//  - The top level holds capture steering, cwri mux and overflow_err.
// TESTING
//  1. Hold rst for 2 clk with cwsi=1. Then all requests=0, data_out_*=0, overflow_err=0, and cwri=1 in both phases.
//  2. Polarity=1, cwsi=1, cwdi=0x00_03_..._AA (hop 3). Next cycle: request_cw_even=1, data_out_even=flit, all odd requests 0.
//  3. Polarity=0, flit with hop 0. Then request_pe_odd=1. Grant_pe_odd high 2 cycles: request falls the cycle after grant rises, data holds.
//     Grant falls: odd VC EMPTY next cycle, cwri=1 when polarity=0.
//  4. Fill the even VC with no grant, then send a second flit while polarity=1. Then cwri=0, the second flit is dropped,
//     overflow_err=1, and data_out_even keeps the first flit.
//  5. Both VCs FULL (even hop 2 to CW, odd hop 0 to PE) and both grants pulsed the same cycle. Both VCs go GRANTED
//     independently, and both are EMPTY one cycle after their grants fall.
//  6. Assert rst while the even VC is GRANTED with grant high. Next cycle: even EMPTY, requests 0, data_out_even=0, cwri=1.

Source files
------------

// File: rtl/cw_input_pkg.sv
// rtl/cw_input_pkg.sv - shared ring-router definitions for the CW input port
package cw_input_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int HOP_MSB        = 55;
  localparam int HOP_LSB        = 48;
  localparam int HOP_WIDTH      = HOP_MSB - HOP_LSB + 1;

  typedef enum logic [2:0] {
    VC_EMPTY   = 3'b001,
    VC_FULL    = 3'b010,
    VC_GRANTED = 3'b100
  } vc_state_t;

  function automatic logic hop_is_zero(input logic [HOP_WIDTH-1:0] hop);
    return hop == '0;
  endfunction

endpackage

// File: rtl/cw_input_vc.sv
// rtl/cw_input_vc.sv - one virtual-channel buffer with request/grant handshake
module cw_input_vc
  import cw_input_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_capture,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_grant_cw,
  input  logic                  i_grant_pe,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_req_cw,
  output logic                  o_req_pe,
  output logic                  o_empty
);

  vc_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dest_pe;
  logic                  r_req_cw;
  logic                  r_req_pe;

  logic w_hop_zero;
  logic w_grant;

  assign w_hop_zero = hop_is_zero(i_data[HOP_MSB:HOP_LSB]);
  // Only the grant from the destination chosen at capture counts.
  assign w_grant    = r_dest_pe ? i_grant_pe : i_grant_cw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= VC_EMPTY;
      r_data    <= '0;
      r_dest_pe <= 1'b0;
      r_req_cw  <= 1'b0;
      r_req_pe  <= 1'b0;
    end else begin
      case (r_state)
        VC_EMPTY: begin
          if (i_capture) begin
            r_state   <= VC_FULL;
            r_data    <= i_data;
            r_dest_pe <= w_hop_zero;
            r_req_pe  <= w_hop_zero;
            r_req_cw  <= ~w_hop_zero;
          end
        end
        VC_FULL: begin
          if (w_grant) begin
            r_state  <= VC_GRANTED;
            r_req_cw <= 1'b0;
            r_req_pe <= 1'b0;
          end
        end
        // Data stays put here: the output port re-samples it while grant is high.
        VC_GRANTED: begin
          if (!w_grant) begin
            r_state <= VC_EMPTY;
          end
        end
        default: begin
          r_state  <= VC_EMPTY;
          r_req_cw <= 1'b0;
          r_req_pe <= 1'b0;
        end
      endcase
    end
  end

  assign o_data   = r_data;
  assign o_req_cw = r_req_cw;
  assign o_req_pe = r_req_pe;
  assign o_empty  = (r_state == VC_EMPTY);

endmodule

// File: rtl/cw_input.sv
// rtl/cw_input.sv - clockwise-link input port: capture steering, cwri and overflow
module cw_input
  import cw_input_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  cwsi,
  input  logic [DATA_WIDTH-1:0] cwdi,
  output logic                  cwri,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd,
  output logic                  request_cw_even,
  output logic                  request_cw_odd,
  output logic                  request_pe_even,
  output logic                  request_pe_odd,
  input  logic                  grant_cw_even,
  input  logic                  grant_cw_odd,
  input  logic                  grant_pe_even,
  input  logic                  grant_pe_odd,
  output logic                  overflow_err
);

  logic w_cap_even;
  logic w_cap_odd;
  logic w_even_empty;
  logic w_odd_empty;
  logic r_overflow;

  // The sender launches on the negedge after its polarity check, so polarity=1 lands in even.
  assign w_cap_even = cwsi & polarity;
  assign w_cap_odd  = cwsi & ~polarity;

  cw_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_even (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_cap_even),
    .i_data    (cwdi),
    .i_grant_cw(grant_cw_even),
    .i_grant_pe(grant_pe_even),
    .o_data    (data_out_even),
    .o_req_cw  (request_cw_even),
    .o_req_pe  (request_pe_even),
    .o_empty   (w_even_empty)
  );

  cw_input_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_odd (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_cap_odd),
    .i_data    (cwdi),
    .i_grant_cw(grant_cw_odd),
    .i_grant_pe(grant_pe_odd),
    .o_data    (data_out_odd),
    .o_req_cw  (request_cw_odd),
    .o_req_pe  (request_pe_odd),
    .o_empty   (w_odd_empty)
  );

  assign cwri = polarity ? w_odd_empty : w_even_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if ((w_cap_even && !w_even_empty) || (w_cap_odd && !w_odd_empty)) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_cw_input.sv
// tb/tb_cw_input.sv - scoreboard bench for cw_input
module tb_cw_input;

  logic        clk;
  logic        rst;
  logic        polarity;
  logic        cwsi;
  logic [63:0] cwdi;
  logic        cwri;
  logic [63:0] data_out_even;
  logic [63:0] data_out_odd;
  logic        request_cw_even;
  logic        request_cw_odd;
  logic        request_pe_even;
  logic        request_pe_odd;
  logic        grant_cw_even;
  logic        grant_cw_odd;
  logic        grant_pe_even;
  logic        grant_pe_odd;
  logic        overflow_err;

  typedef struct {
    logic        cw;
    logic        pe;
    logic [63:0] data;
  } exp_t;

  exp_t q_even[$];
  exp_t q_odd[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_even = 1'b0;
  logic prev_odd  = 1'b0;

  localparam logic [63:0] F2  = 64'h0003_0000_0000_00AA;
  localparam logic [63:0] F3  = 64'h1100_0000_0000_0055;
  localparam logic [63:0] F4A = 64'h0005_0000_0000_0001;
  localparam logic [63:0] F4B = 64'hFF00_0000_0000_00BB;
  localparam logic [63:0] F5E = 64'h0002_0000_0000_0E0E;
  localparam logic [63:0] F5O = 64'h0000_0000_0000_0D0D;
  localparam logic [63:0] F6  = 64'h0001_0000_0000_0066;

  cw_input dut (
    .clk            (clk),
    .rst            (rst),
    .polarity       (polarity),
    .cwsi           (cwsi),
    .cwdi           (cwdi),
    .cwri           (cwri),
    .data_out_even  (data_out_even),
    .data_out_odd   (data_out_odd),
    .request_cw_even(request_cw_even),
    .request_cw_odd (request_cw_odd),
    .request_pe_even(request_pe_even),
    .request_pe_odd (request_pe_odd),
    .grant_cw_even  (grant_cw_even),
    .grant_cw_odd   (grant_cw_odd),
    .grant_pe_even  (grant_pe_even),
    .grant_pe_odd   (grant_pe_odd),
    .overflow_err   (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cwri(input string name, input logic exp_p0, input logic exp_p1);
    logic save;
    save = polarity;
    polarity = 1'b0;
    #1;
    chk({name, "_p0"}, 64'(cwri), 64'(exp_p0));
    polarity = 1'b1;
    #1;
    chk({name, "_p1"}, 64'(cwri), 64'(exp_p1));
    polarity = save;
    #1;
  endtask

  task automatic send(input logic pol, input logic [63:0] flit, input logic expect_store);
    exp_t e;
    polarity = pol;
    cwsi     = 1'b1;
    cwdi     = flit;
    if (expect_store) begin
      e.cw   = (flit[55:48] != 8'h00);
      e.pe   = (flit[55:48] == 8'h00);
      e.data = flit;
      if (pol) q_even.push_back(e);
      else     q_odd.push_back(e);
    end
    step();
    cwsi = 1'b0;
    cwdi = '0;
  endtask

  // Monitor: each new request on a VC must match the next expected flit for that VC.
  always @(negedge clk) begin
    if ((request_cw_even || request_pe_even) && !prev_even) begin
      if (q_even.size() == 0) begin
        chk("even_unexpected_req", 64'd1, 64'd0);
      end else begin
        chk("sb_even_req_cw", 64'(request_cw_even), 64'(q_even[0].cw));
        chk("sb_even_req_pe", 64'(request_pe_even), 64'(q_even[0].pe));
        chk("sb_even_data", data_out_even, q_even[0].data);
        void'(q_even.pop_front());
      end
    end
    if ((request_cw_odd || request_pe_odd) && !prev_odd) begin
      if (q_odd.size() == 0) begin
        chk("odd_unexpected_req", 64'd1, 64'd0);
      end else begin
        chk("sb_odd_req_cw", 64'(request_cw_odd), 64'(q_odd[0].cw));
        chk("sb_odd_req_pe", 64'(request_pe_odd), 64'(q_odd[0].pe));
        chk("sb_odd_data", data_out_odd, q_odd[0].data);
        void'(q_odd.pop_front());
      end
    end
    prev_even <= request_cw_even || request_pe_even;
    prev_odd  <= request_cw_odd || request_pe_odd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; polarity = 1'b1; cwsi = 1'b1; cwdi = F2;
    grant_cw_even = 1'b0; grant_cw_odd = 1'b0; grant_pe_even = 1'b0; grant_pe_odd = 1'b0;

    // Reset held with the link strobing into both phases
    step();
    polarity = 1'b0;
    step();
    rst = 1'b0; cwsi = 1'b0; cwdi = '0;
    chk("rst_reqs", 64'({request_cw_even, request_cw_odd, request_pe_even, request_pe_odd}), 64'd0);
    chk("rst_data_even", data_out_even, 64'd0);
    chk("rst_data_odd", data_out_odd, 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk_cwri("rst_cwri", 1'b1, 1'b1);

    // Even capture, hop 3 -> CW
    send(1'b1, F2, 1'b1);
    chk("t2_req_cw_even", 64'(request_cw_even), 64'd1);
    chk("t2_odd_reqs", 64'({request_cw_odd, request_pe_odd}), 64'd0);
    chk("t2_data_even", data_out_even, F2);
    grant_cw_even = 1'b1;
    step();
    chk("t2_granted_req", 64'(request_cw_even), 64'd0);
    chk("t2_granted_data", data_out_even, F2);
    grant_cw_even = 1'b0;
    step();
    chk_cwri("t2_freed_cwri", 1'b1, 1'b1);

    // Odd capture, hop 0 -> PE, grant held for two cycles
    send(1'b0, F3, 1'b1);
    chk("t3_req_pe_odd", 64'(request_pe_odd), 64'd1);
    chk("t3_req_cw_odd", 64'(request_cw_odd), 64'd0);
    grant_pe_odd = 1'b1;
    step();
    chk("t3_g1_req", 64'(request_pe_odd), 64'd0);
    chk("t3_g1_data", data_out_odd, F3);
    step();
    chk("t3_g2_req", 64'(request_pe_odd), 64'd0);
    chk("t3_g2_data", data_out_odd, F3);
    chk_cwri("t3_busy_cwri", 1'b1, 1'b0);
    grant_pe_odd = 1'b0;
    step();
    chk_cwri("t3_freed_cwri", 1'b1, 1'b1);
    chk("t3_no_overflow", 64'(overflow_err), 64'd0);

    // Overflow: second flit into a full even VC is dropped
    send(1'b1, F4A, 1'b1);
    send(1'b1, F4B, 1'b0);
    chk("t4_overflow", 64'(overflow_err), 64'd1);
    chk("t4_data_kept", data_out_even, F4A);
    chk("t4_req_cw_even", 64'(request_cw_even), 64'd1);
    chk("t4_req_pe_even", 64'(request_pe_even), 64'd0);
    chk_cwri("t4_cwri", 1'b0, 1'b1);
    grant_cw_even = 1'b1;
    step();
    grant_cw_even = 1'b0;
    step();
    chk("t4_overflow_sticky", 64'(overflow_err), 64'd1);

    // Both VCs full; wrong-destination grants ignored, then simultaneous grants
    send(1'b1, F5E, 1'b1);
    send(1'b0, F5O, 1'b1);
    chk("t5_both_reqs", 64'({request_cw_even, request_pe_odd}), 64'b11);
    grant_pe_even = 1'b1; grant_cw_odd = 1'b1;
    step();
    grant_pe_even = 1'b0; grant_cw_odd = 1'b0;
    chk("t5_wrong_grant_ignored", 64'({request_cw_even, request_pe_odd}), 64'b11);
    grant_cw_even = 1'b1; grant_pe_odd = 1'b1;
    step();
    chk("t5_granted_reqs", 64'({request_cw_even, request_cw_odd, request_pe_even, request_pe_odd}), 64'd0);
    chk("t5_data_even", data_out_even, F5E);
    chk("t5_data_odd", data_out_odd, F5O);
    chk_cwri("t5_busy_cwri", 1'b0, 1'b0);
    grant_cw_even = 1'b0; grant_pe_odd = 1'b0;
    step();
    chk_cwri("t5_freed_cwri", 1'b1, 1'b1);

    // Reset while even VC is granted
    send(1'b1, F6, 1'b1);
    grant_cw_even = 1'b1;
    step();
    chk("t6_granted", 64'(request_cw_even), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_reqs", 64'({request_cw_even, request_cw_odd, request_pe_even, request_pe_odd}), 64'd0);
    chk("t6_data_even", data_out_even, 64'd0);
    chk("t6_overflow", 64'(overflow_err), 64'd0);
    chk_cwri("t6_cwri", 1'b1, 1'b1);
    grant_cw_even = 1'b0;
    step();
    step();

    chk("sb_even_drained", 64'(q_even.size()), 64'd0);
    chk("sb_odd_drained", 64'(q_odd.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
